// File: rtl/npc_btb.sv
// rtl/npc_btb.sv - fetch-stage PC register with direct-mapped BTB and 2-bit direction counters
module npc_btb #(
  parameter int          ENTRIES  = 16,
  parameter int          IDX_W    = $clog2(ENTRIES),
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  output logic [31:0] pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic        upd_is_jump,
  input  logic [31:0] upd_target
);

  localparam int TAG_W = 30 - IDX_W;

  logic [ENTRIES-1:0] valid;
  logic [TAG_W-1:0]   tag_mem [ENTRIES];
  logic [29:0]        tgt_mem [ENTRIES];
  logic [1:0]         ctr_mem [ENTRIES];

  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] u_idx;
  logic             hit;
  logic             u_hit;
  logic             u_taken;
  logic [1:0]       u_ctr;
  logic [31:0]      pc_plus4;

  // Low address bits are architecturally zero for word-aligned fetch.
  logic unused_lsbs;
  assign unused_lsbs = ^{redirect_pc[1:0], upd_pc[1:0], upd_target[1:0]};

  assign idx         = pc[IDX_W+1:2];
  assign hit         = valid[idx] && (tag_mem[idx] == pc[31:IDX_W+2]);
  assign pred_taken  = hit && ctr_mem[idx][1];
  assign pc_plus4    = pc + 32'd4;
  assign pred_target = pred_taken ? {tgt_mem[idx], 2'b00} : pc_plus4;

  assign u_idx   = upd_pc[IDX_W+1:2];
  assign u_hit   = valid[u_idx] && (tag_mem[u_idx] == upd_pc[31:IDX_W+2]);
  assign u_taken = upd_taken || upd_is_jump;

  always_comb begin
    u_ctr = ctr_mem[u_idx];
    if (upd_is_jump)
      u_ctr = 2'd3;
    else if (upd_taken)
      u_ctr = (ctr_mem[u_idx] == 2'd3) ? 2'd3 : ctr_mem[u_idx] + 2'd1;
    else
      u_ctr = (ctr_mem[u_idx] == 2'd0) ? 2'd0 : ctr_mem[u_idx] - 2'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc <= RESET_PC;
    end else if (redirect_valid) begin
      pc <= {redirect_pc[31:2], 2'b00};
    end else if (!stall) begin
      pc <= pred_target;
    end
  end

  // Not-taken misses never allocate, so a resident taken entry survives aliasing.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_mem[i] <= '0;
        tgt_mem[i] <= '0;
        ctr_mem[i] <= 2'd0;
      end
    end else if (upd_valid) begin
      if (u_hit) begin
        ctr_mem[u_idx] <= u_ctr;
        if (u_taken)
          tgt_mem[u_idx] <= upd_target[31:2];
      end else if (u_taken) begin
        valid[u_idx]   <= 1'b1;
        tag_mem[u_idx] <= upd_pc[31:IDX_W+2];
        tgt_mem[u_idx] <= upd_target[31:2];
        ctr_mem[u_idx] <= upd_is_jump ? 2'd3 : 2'd2;
      end
    end
  end

endmodule

// File: tb/tb_npc_btb.sv
// tb/tb_npc_btb.sv - scoreboard bench for npc_btb
module tb_npc_btb;

  logic        clk;
  logic        reset;
  logic        stall;
  logic [31:0] pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic        upd_is_jump;
  logic [31:0] upd_target;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  npc_btb #(.ENTRIES(16), .RESET_PC(32'h0000_3000)) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .pc            (pc),
    .pred_taken    (pred_taken),
    .pred_target   (pred_target),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .upd_valid     (upd_valid),
    .upd_pc        (upd_pc),
    .upd_taken     (upd_taken),
    .upd_is_jump   (upd_is_jump),
    .upd_target    (upd_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic compare_state(input exp_t e);
    check({e.tag, ".pc"}, pc, e.pc);
    check({e.tag, ".taken"}, {31'd0, pred_taken}, {31'd0, e.taken});
    check({e.tag, ".target"}, pred_target, e.target);
  endtask

  // Push the expected post-edge state, clock once, then pop and compare.
  task automatic cyc(input string tag, input logic [31:0] e_pc, input logic e_tk,
                     input logic [31:0] e_tgt);
    exp_t e;
    e.tag = tag; e.pc = e_pc; e.taken = e_tk; e.target = e_tgt;
    sb.push_back(e);
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    upd_valid      = 1'b0;
    compare_state(sb.pop_front());
  endtask

  task automatic redir(input logic [31:0] a);
    redirect_valid = 1'b1;
    redirect_pc    = a;
  endtask

  task automatic train(input logic [31:0] a, input logic tk, input logic jmp,
                       input logic [31:0] t);
    upd_valid   = 1'b1;
    upd_pc      = a;
    upd_taken   = tk;
    upd_is_jump = jmp;
    upd_target  = t;
  endtask

  initial begin
    exp_t e;
    reset = 1'b0; stall = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_is_jump = 1'b0; upd_target = '0;

    @(posedge clk); #1;
    e.tag = "reset"; e.pc = 32'h3000; e.taken = 1'b0; e.target = 32'h3004;
    sb.push_back(e);
    compare_state(sb.pop_front());
    reset = 1'b1;

    cyc("seq0", 32'h3004, 1'b0, 32'h3008);
    cyc("seq1", 32'h3008, 1'b0, 32'h300C);
    cyc("seq2", 32'h300C, 1'b0, 32'h3010);

    train(32'h3008, 1'b1, 1'b0, 32'h3040); redir(32'h3040);
    cyc("alloc", 32'h3040, 1'b0, 32'h3044);
    redir(32'h3000);
    cyc("redir3000", 32'h3000, 1'b0, 32'h3004);
    cyc("walk3004", 32'h3004, 1'b0, 32'h3008);
    cyc("predict", 32'h3008, 1'b1, 32'h3040);
    cyc("follow", 32'h3040, 1'b0, 32'h3044);

    train(32'h3008, 1'b0, 1'b0, 32'h0); redir(32'h3008);
    cyc("ctr1", 32'h3008, 1'b0, 32'h300C);
    cyc("ctr1_next", 32'h300C, 1'b0, 32'h3010);
    train(32'h3008, 1'b1, 1'b0, 32'h3040);
    cyc("inc_a", 32'h3010, 1'b0, 32'h3014);
    train(32'h3008, 1'b1, 1'b0, 32'h3040);
    cyc("inc_b", 32'h3014, 1'b0, 32'h3018);
    train(32'h3008, 1'b0, 1'b0, 32'h0); redir(32'h3008);
    cyc("ctr3to2", 32'h3008, 1'b1, 32'h3040);
    cyc("ctr2_follow", 32'h3040, 1'b0, 32'h3044);

    train(32'h3010, 1'b1, 1'b1, 32'h3100); redir(32'h3010);
    cyc("jump", 32'h3010, 1'b1, 32'h3100);
    cyc("jump_follow", 32'h3100, 1'b0, 32'h3104);
    train(32'h3050, 1'b1, 1'b0, 32'h3200); redir(32'h3010);
    cyc("alias_evict", 32'h3010, 1'b0, 32'h3014);
    train(32'h3090, 1'b0, 1'b0, 32'h0); redir(32'h3050);
    cyc("alias_keep", 32'h3050, 1'b1, 32'h3200);

    stall = 1'b1; redir(32'h4003);
    cyc("redir_over_stall", 32'h4000, 1'b0, 32'h4004);
    for (int i = 0; i < 4; i++) cyc("stall_hold", 32'h4000, 1'b0, 32'h4004);

    train(32'h4000, 1'b1, 1'b0, 32'h5000);
    #1;
    check("same_idx_old", {31'd0, pred_taken}, 32'd0);
    cyc("same_idx_new", 32'h4000, 1'b1, 32'h5000);
    stall = 1'b0;
    cyc("unstall", 32'h5000, 1'b0, 32'h5004);

    redir(32'hFFFF_FFFC);
    cyc("wrap_top", 32'hFFFF_FFFC, 1'b0, 32'h0000_0000);
    cyc("wrap_zero", 32'h0000_0000, 1'b0, 32'h0000_0004);

    #2;
    reset = 1'b0;
    #1;
    e.tag = "async_reset"; e.pc = 32'h3000; e.taken = 1'b0; e.target = 32'h3004;
    sb.push_back(e);
    compare_state(sb.pop_front());
    cyc("reset_hold", 32'h3000, 1'b0, 32'h3004);
    reset = 1'b1;
    redir(32'h3008);
    cyc("cleared_3008", 32'h3008, 1'b0, 32'h300C);
    redir(32'h3050);
    cyc("cleared_3050", 32'h3050, 1'b0, 32'h3054);

    check("scoreboard_empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/npc_btb.md
# npc_btb

Parametrised fetch-stage next-PC unit with a direct-mapped branch target buffer (BTB) and 2-bit saturating direction counters. It owns the F-stage PC register. Each cycle it predicts the next fetch address from the BTB, and it accepts redirect and training information from D-stage branch/jump resolution. It replaces static PC+4 sequencing in front of the D-stage target computation.

## Interface
Parameters:
- ENTRIES, 16, number of BTB entries; power of two, 2..256.
- IDX_W, $clog2(ENTRIES), index width; derived, not overridden.
- RESET_PC, 32'h0000_3000, PC value after reset; word aligned.

Ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- stall  in  1  hold PC (F stage frozen).
- pc  out  32  current fetch PC, registered.
- pred_taken  out  1  prediction for `pc`, combinational from `pc` and BTB state.
- pred_target  out  32  predicted next PC: BTB target if pred_taken, else pc+4.
- redirect_valid  in  1  D-stage mispredict or correction.
- redirect_pc  in  32  correct next PC; bits [1:0] ignored and forced to 0.
- upd_valid  in  1  D-stage resolved a branch or jump this cycle.
- upd_pc  in  32  address of the resolved instruction.
- upd_taken  in  1  resolved direction; jumps are always 1.
- upd_is_jump  in  1  unconditional jump (j/jal).
- upd_target  in  32  resolved target address.

## Operation
- Entry fields: valid (1), tag (pc[31:2+IDX_W]), target[31:2], ctr (2 bits).
- Index is pc[IDX_W+1:2].
- Lookup: hit = valid && tag match. pred_taken = hit && ctr[1].
- PC register update, in priority order:
  - redirect_valid loads {redirect_pc[31:2],2'b00}; redirect wins over stall.
  - Else stall holds pc.
  - Else pc loads pred_target.
- pc+4 is computed modulo 2^32: 32'hFFFF_FFFC wraps to 32'h0000_0000.
- Training, on upd_valid, at index of upd_pc:
  - Tag hit, upd_is_jump: ctr=3; target=upd_target.
  - Tag hit, branch taken: ctr=min(ctr+1,3); target=upd_target.
  - Tag hit, branch not taken: ctr=max(ctr-1,0); target unchanged.
  - Tag miss, taken or jump: allocate and overwrite the entry. valid=1, tag, target=upd_target, ctr = 3 for a jump, 2 for a branch.
  - Tag miss, not taken: no change (no allocation).
- Training is independent of stall and redirect; an update and a redirect in the same cycle both take effect.
- Reset state: all entries valid=0, ctr=0. pc=RESET_PC, so pred_taken=0 and pred_target=RESET_PC+4.

## Timing
- Single-cycle: the BTB and pc are written on the rising clk edge. Lookup is combinational.
- Same-cycle training and lookup at the same index: lookup returns pre-edge contents, with no bypass. The new contents are visible from the next cycle.
- Redirect latency: redirect_valid at edge N gives pc=redirect_pc after edge N.
- Stall: pc, pred_taken and pred_target are constant while stall=1, unless a training write at the current index lands (prediction may change; pc does not).
- Reset asserted mid-operation clears state immediately, independent of clk. Releasing reset takes effect at the first edge after release.
- Aliasing is expected: a different tag at the same index replaces the entry only when a taken instruction is allocated.

## Test plan
- Reset and sequence:
  - Assert reset → pc=32'h3000, pred_taken=0.
  - Release for 3 unstalled cycles → pc 3004, 3008, 300C.
- Allocate and predict:
  - upd_valid, upd_pc=3008, taken=1, is_jump=0, target=3040.
  - Redirect to 3040, then later redirect to 3000 → when pc reaches 3008, pred_taken=1 (ctr=2) and next pc=3040.
- Counter hysteresis:
  - From ctr=2 at 3008, train not-taken once → ctr=1, pred_taken=0 and next pc=300C.
  - Train taken twice → ctr=3.
  - One not-taken → ctr=2, still taken.
- Jump and alias (ENTRIES=16):
  - Jump at 3010 → 3100 allocates with ctr=3.
  - Taken branch at 3050 (same index 4) replaces the entry; pc=3010 then misses → pred_taken=0.
  - Not-taken at 3090 (index 4, miss) leaves the entry intact.
- Priority and simultaneity:
  - stall=1 with redirect_valid=1, redirect_pc=32'h4003 → pc=32'h4000 next cycle.
  - stall=1 alone for 4 cycles → pc frozen.
  - Training and lookup at the same index in the same cycle → old prediction shown that cycle, new one next.
- Wrap and async reset:
  - Redirect to 32'hFFFF_FFFC, no hit → next pc=0.
  - Assert reset between edges → pc=32'h3000 immediately and all entries invalid.
